// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: 8-bit unsigned samples -> 16-bit signed PCM, sent as I2S with the same word on left and right.
// Latency: a sample accepted during frame N is played in frame N+1 (moved from hold at the next frame boundary).
// Backpressure: sample_ready_o = en_i & ~hold_full, so one sample per frame; AUDIO_I2S_UNDERRUN_CNT_EN adds underrun_cnt_o.
module audio_i2s_tx #(
  parameter int BCLK_HALF_DIV = 2,
  parameter int SLOT_BITS     = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en_i,
  input  logic [7:0]  sample_data_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        frame_req_o,
  output logic        underrun_o,
  output logic        i2s_bclk_o,
  output logic        i2s_lrclk_o,
  output logic        i2s_sdata_o
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt_o
`endif
);

  localparam int DIV_W = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             en_q;
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic             frame_req;
  logic             underrun;
  logic [15:0]      hold;
  logic             hold_full;
  logic [15:0]      frame_word;

  logic             div_wrap;
  logic             fall_evt;
  logic             boundary;
  logic             accept;
  logic [15:0]      pcm;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] slot_b;
  logic [15:0]      word_sh;
  logic             sdata_nxt;
  logic             lrclk_nxt;

  assign sample_ready_o = en_i & ~hold_full;
  assign frame_req_o    = frame_req;
  assign underrun_o     = underrun;
  assign i2s_bclk_o     = bclk;
  assign i2s_lrclk_o    = lrclk;
  assign i2s_sdata_o    = sdata;

  // Event decode: divider wrap, bclk fall, frame boundary, next serial bit.
  always_comb begin
    div_wrap  = (div_cnt == DIV_LAST);
    fall_evt  = en_i & div_wrap & bclk;
    bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    // The first clk with en_i high stands in for the boundary that bit_cnt=0 skipped.
    boundary  = en_i & ((fall_evt & (bit_cnt == BIT_LAST)) | ~en_q);
    accept    = sample_valid_i & sample_ready_o;
    pcm       = {~sample_data_i[7], sample_data_i[6:0], 8'h00};
    slot_b    = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;
    lrclk_nxt = (bit_nxt >= SLOT_LEN);
    // Slot bit b (1..16) carries frame_word[16-b]; b=0 is the one-bclk I2S delay slot.
    word_sh   = frame_word << (slot_b - BIT_W'(1));
    sdata_nxt = 1'b0;
    if (slot_b >= BIT_W'(1) && slot_b <= BIT_W'(16)) begin
      sdata_nxt = word_sh[15];
    end
  end

  // Bit-clock generator and serialiser; everything parks at 0 while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else begin
      en_q <= en_i;
      if (!en_i) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= 1'b0;
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
        if (div_wrap) begin
          bclk <= ~bclk;
        end
        if (fall_evt) begin
          bit_cnt <= bit_nxt;
          lrclk   <= lrclk_nxt;
          sdata   <= sdata_nxt;
        end
      end
    end
  end

  // Hold register and frame word: boundary load wins over a same-cycle accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold       <= 16'h0000;
      hold_full  <= 1'b0;
      frame_word <= 16'h0000;
    end else if (!en_i) begin
      hold_full <= 1'b0;
    end else if (boundary && hold_full) begin
      frame_word <= hold;
      hold_full  <= 1'b0;
    end else if (accept) begin
      hold      <= pcm;
      hold_full <= 1'b1;
    end
  end

  // Frame boundary pulses; an empty hold at the boundary means the last word repeats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_req <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      frame_req <= boundary;
      underrun  <= boundary & ~hold_full;
    end
  end

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
  assign underrun_cnt_o = ucnt;

  // Saturating underrun count; only rstn clears it so it survives enable cycling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ucnt <= 16'h0000;
    end else if (underrun && ucnt != 16'hFFFF) begin
      ucnt <= ucnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a source feeds samples, a monitor rebuilds slot words on bclk rises,
// and the main sequence compares them (plus pulses/handshake) against hand-computed values.
module tb_audio_i2s_tx;

  logic        clk;
  logic        rstn;
  logic        en_i;
  logic [7:0]  sample_data_i;
  logic        sample_valid_i;
  logic        sample_ready_o;
  logic        frame_req_o;
  logic        underrun_o;
  logic        i2s_bclk_o;
  logic        i2s_lrclk_o;
  logic        i2s_sdata_o;
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  audio_i2s_tx #(.BCLK_HALF_DIV(2), .SLOT_BITS(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .en_i           (en_i),
    .sample_data_i  (sample_data_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .frame_req_o    (frame_req_o),
    .underrun_o     (underrun_o),
    .i2s_bclk_o     (i2s_bclk_o),
    .i2s_lrclk_o    (i2s_lrclk_o),
    .i2s_sdata_o    (i2s_sdata_o)
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lr;
    logic [15:0] word;
  } slot_t;

  typedef struct {
    logic ur;
    int   acc;
  } frrec_t;

  typedef struct {
    logic        has_smp;
    logic [7:0]  smp;
    logic [15:0] exp_word;
    logic        exp_ur;
    int          exp_acc;
    int          exp_ucnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_q[$];
  slot_t      slot_q[$];
  frrec_t     fr_q[$];

  // Monitor state
  int          cyc = 0;
  int          mon_idx = -1;
  logic        mon_lr = 1'b0;
  logic [15:0] mon_word = 16'h0000;
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b0;
  int          last_rise = -1;
  int          last_lr_rise = -1;
  int          bclk_per = 0;
  int          lr_per = 0;
  int          acc = 0;
  int          orphan = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input string name, input int nslot, input int nfr);
    int t;
    t = 0;
    while ((slot_q.size() < nslot || fr_q.size() < nfr) && t < 700) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 700) begin
      errors++;
      $display("FAIL %s: timeout, slots %0d frames %0d, expected %0d/%0d",
               name, slot_q.size(), fr_q.size(), nslot, nfr);
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp_word,
                             input logic exp_ur, input int exp_acc);
    slot_t  l;
    slot_t  r;
    frrec_t f;
    wait_for(name, 2, 1);
    if (slot_q.size() >= 2 && fr_q.size() >= 1) begin
      l = slot_q.pop_front();
      r = slot_q.pop_front();
      f = fr_q.pop_front();
      check({name, " left lr"}, {31'd0, l.lr}, 32'd0);
      check({name, " left word"}, {16'd0, l.word}, {16'd0, exp_word});
      check({name, " right lr"}, {31'd0, r.lr}, 32'd1);
      check({name, " right word"}, {16'd0, r.word}, {16'd0, exp_word});
      check({name, " underrun"}, {31'd0, f.ur}, {31'd0, exp_ur});
      check({name, " accepts"}, f.acc, exp_acc);
    end
  endtask

  // Upstream source: presents the queue head, pops it after a real accept.
  initial begin
    logic take;
    sample_valid_i = 1'b0;
    sample_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      take = rstn && sample_valid_i && sample_ready_o;
      @(posedge clk);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        sample_valid_i = 1'b1;
        sample_data_i  = src_q[0];
      end else begin
        sample_valid_i = 1'b0;
      end
    end
  end

  // Monitor: slot words captured on bclk rises, frame records on frame_req pulses.
  always @(negedge clk) begin
    cyc++;
    if (!rstn || !en_i) begin
      mon_idx      = -1;
      mon_lr       = 1'b0;
      prev_bclk    = 1'b0;
      prev_lr      = 1'b0;
      last_rise    = -1;
      last_lr_rise = -1;
      acc          = 0;
    end else begin
      if (frame_req_o) begin
        fr_q.push_back('{ur: underrun_o, acc: acc});
        acc = 0;
      end
      if (underrun_o && !frame_req_o) orphan++;
      if (sample_valid_i && sample_ready_o) acc++;
      if (i2s_bclk_o && !prev_bclk) begin
        if (last_rise >= 0) bclk_per = cyc - last_rise;
        last_rise = cyc;
        if (i2s_lrclk_o != mon_lr) begin
          mon_idx = 0;
          mon_lr  = i2s_lrclk_o;
        end else begin
          mon_idx++;
        end
        if (mon_idx >= 1 && mon_idx <= 16) mon_word[16-mon_idx] = i2s_sdata_o;
        if (mon_idx == 16) slot_q.push_back({mon_lr, mon_word});
      end
      if (i2s_lrclk_o && !prev_lr) begin
        if (last_lr_rise >= 0) lr_per = cyc - last_lr_rise;
        last_lr_rise = cyc;
      end
      prev_bclk = i2s_bclk_o;
      prev_lr   = i2s_lrclk_o;
    end
  end

  vec_t vec[8];

  initial begin
    int pulses;
    int bclk_seen;
    int t;

    vec[0] = '{1'b1, 8'hC0, 16'h0000, 1'b1, 1, 1};
    vec[1] = '{1'b1, 8'hFF, 16'h4000, 1'b0, 0, 1};
    vec[2] = '{1'b1, 8'h00, 16'h7F00, 1'b0, 1, 1};
    vec[3] = '{1'b1, 8'h80, 16'h8000, 1'b0, 1, 1};
    vec[4] = '{1'b1, 8'h40, 16'h0000, 1'b0, 1, 1};
    vec[5] = '{1'b0, 8'h00, 16'hC000, 1'b0, 1, 1};
    vec[6] = '{1'b0, 8'h00, 16'hC000, 1'b1, 0, 2};
    vec[7] = '{1'b0, 8'h00, 16'hC000, 1'b1, 0, 3};

    // Reset state
    rstn = 1'b0;
    en_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset bclk", {31'd0, i2s_bclk_o}, 32'd0);
    check("reset lrclk", {31'd0, i2s_lrclk_o}, 32'd0);
    check("reset sdata", {31'd0, i2s_sdata_o}, 32'd0);
    check("reset frame_req", {31'd0, frame_req_o}, 32'd0);
    check("reset underrun", {31'd0, underrun_o}, 32'd0);
    check("reset ready en1", {31'd0, sample_ready_o}, 32'd1);
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    check("reset ucnt", {16'd0, underrun_cnt_o}, 32'd0);
`endif
    en_i = 1'b0;
    #1;
    check("reset ready en0", {31'd0, sample_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Table-driven frames: feed samples, then compare each frame's slots and pulses
    for (int i = 0; i < 8; i++) begin
      if (vec[i].has_smp) src_q.push_back(vec[i].smp);
    end
    repeat (3) @(posedge clk);
    #1;
    en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("enable load frame_req", {31'd0, frame_req_o}, 32'd1);
    check("enable load underrun", {31'd0, underrun_o}, 32'd1);
    check("enable bclk still low", {31'd0, i2s_bclk_o}, 32'd0);
    check("ready low after fill", {31'd0, sample_ready_o}, 32'd0);
    @(negedge clk);
    check("first rise", {31'd0, i2s_bclk_o}, 32'd1);
    check("frame_req one clk", {31'd0, frame_req_o}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      check_frame($sformatf("frame%0d", i), vec[i].exp_word, vec[i].exp_ur, vec[i].exp_acc);
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
      check($sformatf("frame%0d ucnt", i), {16'd0, underrun_cnt_o}, vec[i].exp_ucnt);
`endif
    end
    check("bclk period", bclk_per, 4);
    check("lrclk period", lr_per, 256);

    // Enable dropped mid-left-slot
    t = 0;
    while (!frame_req_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("frame_req before drop", {31'd0, frame_req_o}, 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre-drop bclk", {31'd0, i2s_bclk_o}, 32'd1);
    check("pre-drop sdata", {31'd0, i2s_sdata_o}, 32'd1);
    @(posedge clk);
    #1;
    en_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop bclk", {31'd0, i2s_bclk_o}, 32'd0);
    check("drop lrclk", {31'd0, i2s_lrclk_o}, 32'd0);
    check("drop sdata", {31'd0, i2s_sdata_o}, 32'd0);
    check("drop ready", {31'd0, sample_ready_o}, 32'd0);
    pulses = 0;
    bclk_seen = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(frame_req_o) + int'(underrun_o);
      bclk_seen += int'(i2s_bclk_o);
    end
    check("disabled pulses", pulses, 0);
    check("disabled bclk", bclk_seen, 0);

    // Re-enable with an empty hold: underrun, last word repeats, then refill
    slot_q.delete();
    fr_q.delete();
    @(posedge clk);
    #1;
    en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reenable frame_req", {31'd0, frame_req_o}, 32'd1);
    check("reenable underrun", {31'd0, underrun_o}, 32'd1);
    check("reenable ready", {31'd0, sample_ready_o}, 32'd1);
    src_q.push_back(8'h00);
    check_frame("reen frame0", 16'hC000, 1'b1, 0);
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    check("reen ucnt", {16'd0, underrun_cnt_o}, 32'd5);
`endif
    check_frame("reen frame1", 16'h8000, 1'b0, 1);

    // Reset mid-frame with a full hold
    src_q.push_back(8'hFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("hold full ready", {31'd0, sample_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midreset bclk", {31'd0, i2s_bclk_o}, 32'd0);
    check("midreset lrclk", {31'd0, i2s_lrclk_o}, 32'd0);
    check("midreset sdata", {31'd0, i2s_sdata_o}, 32'd0);
    check("midreset frame_req", {31'd0, frame_req_o}, 32'd0);
    check("midreset ready", {31'd0, sample_ready_o}, 32'd1);
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    check("midreset ucnt", {16'd0, underrun_cnt_o}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    slot_q.delete();
    fr_q.delete();
    #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post-reset underrun", {31'd0, underrun_o}, 32'd1);
    check_frame("post-reset frame0", 16'h0000, 1'b1, 0);
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    check("post-reset ucnt", {16'd0, underrun_cnt_o}, 32'd1);
`endif
    check("orphan underruns", orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
